serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around a single full-adder cell formed from two half-adder cells plus an OR for the carry. It sits directly downstream of the half-adder primitives and consumes their sum/carry each cycle. A carry flip-flop chains the bits, so two WIDTH-bit operands are added LSB-first over WIDTH clock cycles. The block gives the datapath a minimal-area adder with a simple start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock; sole clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request to begin an addition; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- busy  output  1  high while bits are being processed (state ADD).
- done  output  1  one-cycle pulse; sum/carry_out are valid and new.
- sum  output  WIDTH  registered result, A+B mod 2^WIDTH.
- carry_out  output  1  registered carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start=1 loads a, b into shift registers sa, sb.
  - Clears the carry flop and the accumulator shift register.
  - Sets bit counter cnt=0 and moves to ADD.
  - start=0 stays in IDLE.
- ADD, per edge:
  - ha1 = sa[0]^sb[0], c1 = sa[0]&sb[0].
  - s = ha1^carry, c2 = ha1&carry.
  - carry <= c1|c2.
  - The accumulator shifts right with s entering at bit WIDTH-1; sa and sb shift right.
  - cnt increments.
- ADD exit: on the edge where cnt==WIDTH-1, go to DONE. On that same edge, sum <= the final accumulator value (including this edge's s bit) and carry_out <= c1|c2.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- start is ignored in ADD and DONE; operands are never re-sampled mid-operation.
- sum and carry_out change only on the ADD→DONE edge and on reset; they hold their value through IDLE and through the next ADD.
- Counter width: $clog2(WIDTH) bits, minimum 1. WIDTH=1 completes after one ADD edge.
- Overflow wraps modulo 2^WIDTH; the lost bit appears on carry_out.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, busy=0, done=0, sum=0, carry_out=0.
  - Internal shift registers, carry and cnt are cleared.
- Reset mid-ADD or in DONE aborts the operation: no done pulse, and the result is discarded.
- rst_n has priority over start on the same edge.
- Start accepted at edge E0:
  - busy=1 from E0 to E0+WIDTH.
  - done=1 from E_WIDTH to E_WIDTH+1.
  - Latency is WIDTH cycles from the accepting edge to done.
- busy and done are never high together.
- Earliest next accept is edge E_WIDTH+2; at edge E_WIDTH+1 the FSM is still in DONE and start is ignored.
- Throughput: one addition per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulsed: done exactly 8 cycles after the accepting edge with sum=0x96, carry_out=0; busy high for 8 cycles.
- WIDTH=8, a=0xFF, b=0x01 → sum=0x00, carry_out=1. Then a=0xFF, b=0xFF → sum=0xFE, carry_out=1.
- WIDTH=1, all four {a,b} combinations → sum/carry_out equal the half-adder truth table (0/0, 1/0, 1/0, 0/1), each done 1 cycle after accept.
- start held high continuously with a changing every cycle:
  - only values sampled at the IDLE accepts are used;
  - accepts occur every WIDTH+2 cycles;
  - each result matches its own sampled operands.
- rst_n=0 asserted 3 cycles into an 8-bit add of 0x12+0x34: busy, done, sum and carry_out are 0 after the edge, and no done pulse follows. A fresh start then yields 0x46/0.
- Run 0x10+0x20 to completion, then start 0xF0+0xF0: sum holds 0x30 throughout the second ADD, then updates to 0xE0 with carry_out=1 on the done edge.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder cell from two half adders
// LSB-first over WIDTH cycles with a start/done handshake; all outputs registered.

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             ha1;
   logic             c1;
   logic             c2;
   logic             s_bit;
   logic             c_next;

   half_adder u_ha1 (.x(sa[0]), .y(sb[0]), .s(ha1),   .c(c1));
   half_adder u_ha2 (.x(ha1),   .y(carry), .s(s_bit), .c(c2));
   assign c_next = c1 | c2;

   // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the LSB result.
   generate
      if (WIDTH == 1) begin : g_acc_one
         assign acc_next = s_bit;
      end else begin : g_acc_wide
         assign acc_next = {s_bit, acc[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sa        <= '0;
         sb        <= '0;
         acc       <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  acc   <= '0;
                  cnt   <= '0;
                  carry <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               carry <= c_next;
               acc   <= acc_next;
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  sum       <= acc_next;
                  carry_out <= c_next;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder at WIDTH 8 and 1

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       start1 = 1'b0;
   logic       a1 = 1'b0;
   logic       b1 = 1'b0;
   logic       busy1, done1, cout1;
   logic       sum1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
   );

   // Drives one operation from a negedge with the DUT idle; reports latency,
   // busy cycle count and the result seen on the done cycle (lat=-1 on timeout).
   task automatic do_op(input bit w1, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int bc, output logic [7:0] s, output logic c);
      lat = -1;
      bc  = 0;
      s   = '0;
      c   = 1'b0;
      @(negedge clk);
      if (w1) begin start1 = 1'b1; a1 = av[0]; b1 = bv[0]; end
      else    begin start8 = 1'b1; a8 = av;    b8 = bv;    end
      @(posedge clk);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 0) begin start1 = 1'b0; start8 = 1'b0; end
         if (w1 ? busy1 : busy8) bc++;
         if (w1 ? done1 : done8) begin
            lat = i;
            s   = w1 ? {7'd0, sum1} : sum8;
            c   = w1 ? cout1 : cout8;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset8: busy=%0b done=%0b sum=%h cout=%0b, required all 0", busy8, done8, sum8, cout8);
      end
      n_tests++;
      if ({busy1, done1, sum1, cout1} !== 4'd0) begin
         n_fail++;
         $display("FAIL reset1: busy=%0b done=%0b sum=%0b cout=%0b, required all 0", busy1, done1, sum1, cout1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'hFF};
      logic [7:0] tb [3] = '{8'h3C, 8'h01, 8'hFF};
      int lat, bc;
      logic [7:0] s;
      logic c;
      logic [8:0] exp;
      for (int k = 0; k < 3; k++) begin
         exp = {1'b0, ta[k]} + {1'b0, tb[k]};
         do_op(1'b0, ta[k], tb[k], lat, bc, s, c);
         n_tests++;
         if (lat !== 8 || bc !== 8) begin
            n_fail++;
            $display("FAIL directed_timing %h+%h: latency=%0d busy=%0d, required 8/8", ta[k], tb[k], lat, bc);
         end
         n_tests++;
         if ({c, s} !== exp) begin
            n_fail++;
            $display("FAIL directed_result %h+%h: got %0b/%h, required %0b/%h", ta[k], tb[k], c, s, exp[8], exp[7:0]);
         end
      end
   endtask

   task automatic test_width1;
      int lat, bc;
      logic [7:0] s;
      logic c;
      int exp;
      for (int k = 0; k < 4; k++) begin
         exp = (k >> 1) + (k & 1);
         do_op(1'b1, 8'(k >> 1), 8'(k & 1), lat, bc, s, c);
         n_tests++;
         if (lat !== 1 || bc !== 1 || s[0] !== exp[0] || c !== exp[1]) begin
            n_fail++;
            $display("FAIL width1 a=%0d b=%0d: lat=%0d busy=%0d sum=%0b cout=%0b, required 1/1/%0b/%0b",
                     k >> 1, k & 1, lat, bc, s[0], c, exp[0], exp[1]);
         end
      end
   endtask

   task automatic test_random;
      int lat, bc;
      logic [7:0] s, av, bv;
      logic c;
      int exp;
      for (int k = 0; k < 20; k++) begin
         av  = 8'($urandom);
         bv  = 8'($urandom);
         exp = int'(av) + int'(bv);
         do_op(1'b0, av, bv, lat, bc, s, c);
         n_tests++;
         if (lat !== 8 || s !== exp[7:0] || c !== exp[8]) begin
            n_fail++;
            $display("FAIL random %h+%h: lat=%0d got %0b/%h, required 8 %0b/%h", av, bv, lat, c, s, exp[8], exp[7:0]);
         end
      end
   endtask

   // start stays high; accepts expected at edges 0,10,20,30 with dones 8 edges later.
   task automatic test_start_held;
      logic [7:0] av [40];
      logic [7:0] bv [40];
      int exp;
      bit exp_done;
      @(negedge clk);
      start8 = 1'b1;
      for (int e = 0; e < 40; e++) begin
         av[e] = 8'($urandom);
         bv[e] = 8'($urandom);
         a8 = av[e];
         b8 = bv[e];
         @(posedge clk);
         @(negedge clk);
         exp_done = (e % 10) == 8;
         n_tests++;
         if (done8 !== exp_done) begin
            n_fail++;
            $display("FAIL held_done edge %0d: done=%0b, required %0b", e, done8, exp_done);
         end
         if (exp_done) begin
            exp = int'(av[e-8]) + int'(bv[e-8]);
            n_tests++;
            if (sum8 !== exp[7:0] || cout8 !== exp[8]) begin
               n_fail++;
               $display("FAIL held_result edge %0d: got %0b/%h, required %0b/%h", e, cout8, sum8, exp[8], exp[7:0]);
            end
         end
      end
      start8 = 1'b0;
   endtask

   task automatic test_reset_mid;
      int lat, bc;
      logic [7:0] s;
      logic c;
      bit seen = 1'b0;
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_tests++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%0b done=%0b sum=%h cout=%0b, required all 0", busy8, done8, sum8, cout8);
      end
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL reset_mid_abort: activity=1 after reset, required 0");
      end
      do_op(1'b0, 8'h12, 8'h34, lat, bc, s, c);
      n_tests++;
      if (lat !== 8 || s !== 8'h46 || c !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_fresh: lat=%0d got %0b/%h, required 8 0/46", lat, c, s);
      end
   endtask

   task automatic test_hold;
      int lat, bc;
      logic [7:0] s;
      logic c;
      bit held = 1'b1;
      bit got = 1'b0;
      do_op(1'b0, 8'h10, 8'h20, lat, bc, s, c);
      n_tests++;
      if (s !== 8'h30 || c !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_first: got %0b/%h, required 0/30", c, s);
      end
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hF0; b8 = 8'hF0;
      @(posedge clk);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (done8) begin
            got = 1'b1;
            n_tests++;
            if (sum8 !== 8'hE0 || cout8 !== 1'b1) begin
               n_fail++;
               $display("FAIL hold_second: got %0b/%h, required 1/e0", cout8, sum8);
            end
            break;
         end
         if (sum8 !== 8'h30 || cout8 !== 1'b0) held = 1'b0;
      end
      n_tests++;
      if (!held || !got) begin
         n_fail++;
         $display("FAIL hold_during_add: held=%0b done_seen=%0b, required 1/1", held, got);
      end
   endtask

   // busy and done must never be high together at any sample point.
   always @(negedge clk) begin
      if (rst_n && ((busy8 && done8) || (busy1 && done1))) begin
         n_tests++;
         n_fail++;
         $display("FAIL busy_done_overlap: busy8=%0b done8=%0b busy1=%0b done1=%0b, required exclusive",
                  busy8, done8, busy1, done1);
      end
   end

   initial begin
      test_reset;
      test_directed;
      test_width1;
      test_random;
      @(negedge clk);
      test_start_held;
      test_reset_mid;
      test_hold;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
